// File: rtl/execute_stage_md.sv
// execute_stage_md
// Execute stage of the pipelined RISC-V core. It contains the following parts:
// - Operand forwarding.
// - A single-cycle ALU.
// - BEQ/BNE branch resolution.
// - The EX/MEM pipeline register.
// - An iterative multiply/divide unit (MUL, MULHU, DIVU, REMU).
//
// The MD unit takes XLEN+2 cycles. While it runs, StallE holds the D and E
// stages and MEM receives bubbles.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, BranchNeE
//                             decoded controls of the op in E
//   ALUControlE[3:0]          operation select (1xxx with [2]=0 selects MD)
//   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW
//                             operands, PC values and writeback value
//   RD_E                      destination register
//   ForwardA_E, ForwardB_E    00/11 regfile, 01 ResultW, 10 ALU_ResultM
//   FlushE                    kill the op in E
//   StallE, PCSrcE, PCTargetE combinational hazard/branch outputs
//   RegWriteM ... ALU_ResultM registered EX/MEM outputs
module execute_stage_md #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               ResultSrcE,
  input  logic               BranchE,
  input  logic               ALUSrcE,
  input  logic               BranchNeE,
  input  logic [3:0]         ALUControlE,
  input  logic [XLEN-1:0]    RD1_E,
  input  logic [XLEN-1:0]    RD2_E,
  input  logic [XLEN-1:0]    Imm_Ext_E,
  input  logic [XLEN-1:0]    PCE,
  input  logic [XLEN-1:0]    PCPlus4E,
  input  logic [XLEN-1:0]    ResultW,
  input  logic [RADDR_W-1:0] RD_E,
  input  logic [1:0]         ForwardA_E,
  input  logic [1:0]         ForwardB_E,
  input  logic               FlushE,
  output logic               StallE,
  output logic               PCSrcE,
  output logic [XLEN-1:0]    PCTargetE,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic               ResultSrcM,
  output logic [RADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]    PCPlus4M,
  output logic [XLEN-1:0]    WriteDataM,
  output logic [XLEN-1:0]    ALU_ResultM
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_t;

  logic [XLEN-1:0]    src_a_s;
  logic [XLEN-1:0]    write_data_s;
  logic [XLEN-1:0]    src_b_s;
  logic [XLEN-1:0]    add_s;
  logic [XLEN-1:0]    sub_s;
  logic [XLEN-1:0]    alu_result_s;
  logic               zero_s;
  logic               md_op_s;
  logic               md_start_s;
  md_state_t          state_r;
  md_state_t          state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [XLEN-1:0]    md_hi_r;
  logic [XLEN-1:0]    md_lo_r;
  logic [XLEN-1:0]    md_b_r;
  logic [1:0]         md_sel_r;
  logic               md_reg_write_r;
  logic               md_mem_write_r;
  logic               md_result_src_r;
  logic [RADDR_W-1:0] md_rd_r;
  logic [XLEN-1:0]    md_pc_plus4_r;
  logic [XLEN-1:0]    md_write_data_r;
  logic [XLEN:0]      mul_sum_s;
  logic [XLEN:0]      div_rem_sh_s;
  logic [XLEN:0]      div_trial_s;
  logic [XLEN-1:0]    md_result_s;

  // Operand forwarding; select 11 falls back to the register file value.
  always_comb begin
    src_a_s      = RD1_E;
    write_data_s = RD2_E;
    case (ForwardA_E)
      2'b01:   src_a_s = ResultW;
      2'b10:   src_a_s = ALU_ResultM;
      default: src_a_s = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   write_data_s = ResultW;
      2'b10:   write_data_s = ALU_ResultM;
      default: write_data_s = RD2_E;
    endcase
  end

  assign src_b_s = ALUSrcE ? Imm_Ext_E : write_data_s;
  assign add_s   = src_a_s + src_b_s;
  assign sub_s   = src_a_s - src_b_s;
  assign zero_s  = (sub_s == ZERO_X);

  // Single-cycle ALU; reserved 11xx codes behave as add.
  always_comb begin
    alu_result_s = add_s;
    case (ALUControlE)
      4'b0000: alu_result_s = add_s;
      4'b0001: alu_result_s = sub_s;
      4'b0010: alu_result_s = src_a_s & src_b_s;
      4'b0011: alu_result_s = src_a_s | src_b_s;
      4'b0100: alu_result_s = src_a_s ^ src_b_s;
      4'b0101: alu_result_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
      4'b0110: alu_result_s = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
      4'b0111: alu_result_s = src_a_s << src_b_s[SH_W-1:0];
      default: alu_result_s = add_s;
    endcase
  end

  assign md_op_s   = (ALUControlE[3:2] == 2'b10);
  assign StallE    = md_op_s & (state_r != ST_DONE) & ~FlushE;
  assign PCSrcE    = BranchE & (zero_s ^ BranchNeE) & ~StallE;
  assign PCTargetE = PCE + Imm_Ext_E;

  // MD next-state logic; a flush aborts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (FlushE) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (md_op_s) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // MD state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign md_start_s = (state_r == ST_IDLE) & (state_nxt_s == ST_BUSY);

  // Multiply: {hi,lo} starts as {0, multiplicand A}. Each step conditionally
  // adds B into hi, then shifts the whole pair right by one bit.
  assign mul_sum_s = {1'b0, md_hi_r} + (md_lo_r[0] ? {1'b0, md_b_r} : {(XLEN+1){1'b0}});

  // Divide: lo holds the dividend and shifts in quotient bits; hi holds the
  // partial remainder. A zero divisor always "fits", so the result is
  // all-ones for the quotient and the dividend for the remainder.
  assign div_rem_sh_s = {md_hi_r, md_lo_r[XLEN-1]};
  assign div_trial_s  = div_rem_sh_s - {1'b0, md_b_r};

  // Select: bit 0 picks the high half (MULHU, REMU).
  assign md_result_s = md_sel_r[0] ? md_hi_r : md_lo_r;

  // MD datapath: latch operands and controls on start, then iterate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r           <= {CNT_W{1'b0}};
      md_hi_r         <= ZERO_X;
      md_lo_r         <= ZERO_X;
      md_b_r          <= ZERO_X;
      md_sel_r        <= 2'b00;
      md_reg_write_r  <= 1'b0;
      md_mem_write_r  <= 1'b0;
      md_result_src_r <= 1'b0;
      md_rd_r         <= {RADDR_W{1'b0}};
      md_pc_plus4_r   <= ZERO_X;
      md_write_data_r <= ZERO_X;
    end else if (md_start_s) begin
      cnt_r           <= {CNT_W{1'b0}};
      md_hi_r         <= ZERO_X;
      md_lo_r         <= src_a_s;
      md_b_r          <= src_b_s;
      md_sel_r        <= ALUControlE[1:0];
      md_reg_write_r  <= RegWriteE;
      md_mem_write_r  <= MemWriteE;
      md_result_src_r <= ResultSrcE;
      md_rd_r         <= RD_E;
      md_pc_plus4_r   <= PCPlus4E;
      md_write_data_r <= write_data_s;
    end else if (state_r == ST_BUSY) begin
      cnt_r <= cnt_r + CNT_ONE;
      if (md_sel_r[1]) begin
        md_hi_r <= div_trial_s[XLEN] ? div_rem_sh_s[XLEN-1:0] : div_trial_s[XLEN-1:0];
        md_lo_r <= {md_lo_r[XLEN-2:0], ~div_trial_s[XLEN]};
      end else begin
        md_hi_r <= mul_sum_s[XLEN:1];
        md_lo_r <= {mul_sum_s[0], md_lo_r[XLEN-1:1]};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // EX/MEM register: bubble on reset, flush or stall; MD result in DONE.
  always_ff @(posedge clk) begin
    if (rst || FlushE || StallE) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= {RADDR_W{1'b0}};
      PCPlus4M    <= ZERO_X;
      WriteDataM  <= ZERO_X;
      ALU_ResultM <= ZERO_X;
    end else if (state_r == ST_DONE) begin
      RegWriteM   <= md_reg_write_r;
      MemWriteM   <= md_mem_write_r;
      ResultSrcM  <= md_result_src_r;
      RD_M        <= md_rd_r;
      PCPlus4M    <= md_pc_plus4_r;
      WriteDataM  <= md_write_data_r;
      ALU_ResultM <= md_result_s;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= write_data_s;
      ALU_ResultM <= alu_result_s;
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;

  logic        clk;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, BranchNeE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        FlushE;
  logic        StallE, PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  typedef struct packed {
    logic [4:0]  rd;
    logic        mw;
    logic        rs;
    logic [31:0] pc4;
    logic [31:0] wd;
    logic [31:0] alu;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  execute_stage_md #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .BranchNeE(BranchNeE),
    .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ResultW(ResultW), .RD_E(RD_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .FlushE(FlushE),
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pc4_of(input logic [4:0] rd);
    return 32'h0000_4000 + {25'd0, rd, 2'b00};
  endfunction

  function automatic logic m_zero();
    return !(RegWriteM | MemWriteM | ResultSrcM) && (RD_M == 5'd0) &&
           (PCPlus4M == 32'd0) && (WriteDataM == 32'd0) && (ALU_ResultM == 32'd0);
  endfunction

  task automatic drive(input logic [3:0] ctl, input logic src, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] rw, input logic [4:0] rd,
                       input logic mw, input logic rs);
    ALUControlE = ctl;  ALUSrcE    = src;  ForwardA_E = fa;  ForwardB_E = fb;
    RD1_E       = a;    RD2_E      = b;    Imm_Ext_E  = imm; ResultW    = rw;
    RD_E        = rd;   MemWriteE  = mw;   ResultSrcE = rs;  RegWriteE  = 1'b1;
    BranchE     = 1'b0; BranchNeE  = 1'b0; FlushE     = 1'b0;
    PCE         = 32'd0; PCPlus4E  = pc4_of(rd);
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    RegWriteE = 1'b0;
  endtask

  task automatic expect_m(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic mw, input logic rs);
    exp_t e;
    e.rd = rd; e.mw = mw; e.rs = rs; e.pc4 = pc4_of(rd); e.wd = wd; e.alu = alu;
    exp_q.push_back(e);
  endtask

  // One single-cycle op in the next cycle, with its expected M values queued.
  task automatic op1(input logic [3:0] ctl, input logic src, input logic [1:0] fa,
                     input logic [1:0] fb, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] imm, input logic [31:0] rw, input logic [4:0] rd,
                     input logic mw, input logic rs, input logic [31:0] ealu,
                     input logic [31:0] ewd);
    @(posedge clk); #1;
    drive(ctl, src, fa, fb, a, b, imm, rw, rd, mw, rs);
    expect_m(ealu, ewd, rd, mw, rs);
  endtask

  // MD op: count stall cycles and M bubbles until DONE; optionally disturb
  // forwarding inputs mid-operation (they must not matter).
  task automatic md_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ealu, input logic [4:0] rd, input logic poke);
    int   stalls  = 0;
    int   bubbles = 0;
    logic done    = 1'b0;
    @(posedge clk); #1;
    drive(ctl, 1'b0, 2'b00, 2'b00, a, b, 32'd0, 32'd0, rd, 1'b0, 1'b0);
    expect_m(ealu, b, rd, 1'b0, 1'b0);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c > 0 && m_zero()) bubbles++;
      if (StallE) stalls++;
      else done = 1'b1;
      if (poke && c == 3) begin
        ForwardA_E = 2'b01; ForwardB_E = 2'b01; ResultW = 32'h0000_1234;
      end
    end
    check("md_stall_cycles", 128'(stalls), 128'(33));
    check("md_bubbles", 128'(bubbles), 128'(33));
  endtask

  // Start a DIVU, abort it at cnt = 10 with FlushE or rst, then run an add.
  task automatic abort(input logic use_rst);
    @(posedge clk); #1;
    drive(4'b1010, 1'b0, 2'b00, 2'b00, 32'd100, 32'd7, 32'd0, 32'd0, 5'd20, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    if (use_rst) begin
      rst = 1'b1;
    end else begin
      FlushE = 1'b1;
      @(negedge clk);
      check("flush_stall", 128'(StallE), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'b0000, 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 5'd21, 1'b0, 1'b0);
    expect_m(32'd7, 32'd4, 5'd21, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_bubble", 128'(m_zero()), 128'(1));
    check("abort_stall", 128'(StallE), 128'(0));
  endtask

  // Scoreboard monitor: every non-bubble M output is matched against the queue.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (!rst && RegWriteM) begin
      got.rd = RD_M; got.mw = MemWriteM; got.rs = ResultSrcM;
      got.pc4 = PCPlus4M; got.wd = WriteDataM; got.alu = ALU_ResultM;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL m_unexpected: got %0h required none", got);
      end else begin
        want = exp_q.pop_front();
        check("m_out", 128'(got), 128'(want));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_m_zero", 128'(m_zero()), 128'(1));
    check("reset_stall", 128'(StallE), 128'(0));

    // Single-cycle ops, back to back.
    op1(4'b0000, 1'b1, 2'b01, 2'b00, 32'hDEAD, 32'h55, 32'h10, 32'd8, 5'd1, 1'b0, 1'b0, 32'h18, 32'h55);
    op1(4'b0001, 1'b1, 2'b10, 2'b00, 32'hDEAD, 32'h66, 32'h10, 32'd0, 5'd2, 1'b0, 1'b0, 32'h8, 32'h66);
    op1(4'b0010, 1'b0, 2'b00, 2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 5'd3, 1'b0, 1'b0, 32'h00F0_1200, 32'h0FF0_FF00);
    op1(4'b0011, 1'b0, 2'b00, 2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 5'd4, 1'b0, 1'b0, 32'hFFF0_FF34, 32'h0FF0_FF00);
    op1(4'b0100, 1'b0, 2'b00, 2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1, 32'hFF00_ED34, 32'h0FF0_FF00);
    op1(4'b0101, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd6, 1'b0, 1'b0, 32'd1, 32'd1);
    op1(4'b0110, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd7, 1'b0, 1'b0, 32'd0, 32'd1);
    op1(4'b0111, 1'b0, 2'b00, 2'b00, 32'd1, 32'h24, 32'd0, 32'd0, 5'd8, 1'b0, 1'b0, 32'h10, 32'h24);
    op1(4'b0001, 1'b0, 2'b00, 2'b01, 32'd100, 32'd999, 32'd0, 32'd30, 5'd9, 1'b0, 1'b0, 32'd70, 32'd30);
    op1(4'b0000, 1'b0, 2'b11, 2'b00, 32'd5, 32'd6, 32'd0, 32'd99, 5'd10, 1'b0, 1'b0, 32'd11, 32'd6);
    op1(4'b1100, 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 5'd11, 1'b0, 1'b0, 32'd7, 32'd4);
    @(negedge clk);
    check("reserved_no_stall", 128'(StallE), 128'(0));

    // Branches (no register write).
    @(posedge clk); #1;
    drive(4'b0001, 1'b0, 2'b00, 2'b00, 32'd5, 32'd5, 32'h40, 32'd0, 5'd0, 1'b0, 1'b0);
    RegWriteE = 1'b0; BranchE = 1'b1; PCE = 32'h0000_1000;
    @(negedge clk);
    check("beq_taken", 128'(PCSrcE), 128'(1));
    check("beq_target", 128'(PCTargetE), 128'(32'h0000_1040));
    @(posedge clk); #1;
    BranchNeE = 1'b1;
    @(negedge clk);
    check("bne_equal", 128'(PCSrcE), 128'(0));
    @(posedge clk); #1;
    RD2_E = 32'd6; PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20;
    @(negedge clk);
    check("bne_taken", 128'(PCSrcE), 128'(1));
    check("target_wrap", 128'(PCTargetE), 128'(32'h10));
    @(posedge clk); #1;
    BranchNeE = 1'b0;
    @(negedge clk);
    check("beq_not_taken", 128'(PCSrcE), 128'(0));
    @(posedge clk); #1;
    idle();

    // Multi-cycle ops, back to back.
    md_op(4'b1000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 5'd12, 1'b1);
    md_op(4'b1001, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 5'd13, 1'b0);
    md_op(4'b1010, 32'd100, 32'd7, 32'd14, 5'd14, 1'b0);
    md_op(4'b1011, 32'd100, 32'd7, 32'd2, 5'd15, 1'b0);
    md_op(4'b1010, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 5'd16, 1'b0);
    md_op(4'b1011, 32'h1234_5678, 32'd0, 32'h1234_5678, 5'd17, 1'b0);
    @(posedge clk); #1;
    idle();

    // Aborts, each followed by a full-length MD op.
    abort(1'b0);
    md_op(4'b1010, 32'd100, 32'd7, 32'd14, 5'd18, 1'b0);
    @(posedge clk); #1;
    idle();
    abort(1'b1);
    md_op(4'b1011, 32'd100, 32'd7, 32'd2, 5'd19, 1'b0);
    @(posedge clk); #1;
    idle();

    repeat (3) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage for the pipelined RISC-V core: operand forwarding, single-cycle ALU, branch resolution and EX/MEM pipeline register, plus an iterative multiply/divide unit. MUL/MULHU/DIVU/REMU stall the front of the pipeline while the unit runs and insert bubbles into MEM. It sits between the decode/ID-EX register and the memory stage, and is driven by the hazard unit's forward, stall and flush controls.

## Interface
Parameters:
- XLEN, 32: datapath width; must be even and ≥ 8.
- RADDR_W, 5: register address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  in  1 each  decoded controls
- BranchNeE  in  1  0 = BEQ, 1 = BNE
- ALUControlE  in  4  operation select, see Operation
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW  in  XLEN  operands and writeback value
- RD_E  in  RADDR_W  destination register
- ForwardA_E, ForwardB_E  in  2  00 = RD1/RD2, 01 = ResultW, 10 = ALU_ResultM, 11 treated as 00
- FlushE  in  1  kill the op currently in E
- StallE  out  1  combinational; hold D and E stages
- PCSrcE  out  1  combinational branch taken
- PCTargetE  out  XLEN  combinational, PCE + Imm_Ext_E, wraps mod 2^XLEN
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered
- RD_M  out  RADDR_W  registered
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN  registered

## Operation
- SrcA is the forwarded A operand. WriteData is the forwarded B operand. SrcB = ALUSrcE ? Imm_Ext_E : WriteData.
- Single-cycle ops:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed), 0110 sltu, 0111 sll (shift by SrcB[log2 XLEN-1:0])
- Multi-cycle (MD) ops, selected when ALUControlE[3] = 1:
  - 1000 MUL: low XLEN bits of the product
  - 1001 MULHU: high XLEN bits of the unsigned product
  - 1010 DIVU, 1011 REMU
  - 11xx is reserved and behaves as add.
- PCSrcE = BranchE & (Zero ^ BranchNeE) & ~StallE, where Zero = (SrcA − SrcB == 0).
- MD state machine:
  - IDLE → BUSY when an MD op is in E, FlushE = 0 and rst = 0. On that edge, latch SrcA/SrcB and the E controls, and set cnt = 0.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; cnt++. When cnt = XLEN−1 at an edge, go to DONE.
  - DONE: result is ready; StallE = 0; on the edge, go to IDLE.
- StallE = MD op in E & state ≠ DONE & ~FlushE.
- Divide by zero: DIVU = all ones, REMU = dividend. No exception is raised.
- EX/MEM register, evaluated on every edge:
  - If rst, FlushE or StallE: load a bubble (all M outputs 0).
  - Otherwise: capture E controls, RD_E and PCPlus4E. WriteDataM = forwarded B. ALU_ResultM = ALU result, or the MD result in DONE.
- FlushE in any state returns the FSM to IDLE and loads a bubble.
- rst mid-operation: FSM → IDLE, cnt = 0, all M outputs 0.

## Timing
- Reset values: all registered outputs 0, FSM IDLE, cnt 0.
- Single-cycle op: visible on the M outputs one edge after it is presented.
- MD op presented in cycle 0 (FSM IDLE):
  - StallE is high in cycles 0..XLEN and low in cycle XLEN+1 (DONE).
  - The result appears on ALU_ResultM after the edge ending cycle XLEN+1.
  - M shows a bubble for each of the XLEN+1 stalled cycles.
- Operands are sampled only in cycle 0. Changes to ResultW or forward selects during BUSY have no effect.
- Back-to-back MD ops: the second op sees IDLE in the cycle after DONE and starts with no extra gap.
- FlushE has priority over StallE. rst has priority over everything.

## Test plan
- Reset: hold rst for 2 cycles → all M outputs 0, StallE = 0.
- Forwarded add: ALUControlE = 0000, ALUSrcE = 1, Imm = 0x10, ForwardA = 01, ResultW = 8 → next edge ALU_ResultM = 0x18, RegWriteM = 1. Sub with ForwardA = 10 and prior ALU_ResultM = 0x18, Imm = 0x10 → 0x8.
- MUL 0xFFFF_FFFF × 3 (XLEN = 32): StallE high for exactly 33 cycles with bubbles in M. Then ALU_ResultM = 0xFFFF_FFFD; MULHU of the same operands = 0x2.
- DIVU 100 / 7 → 14; REMU → 2. DIVU x / 0 → 0xFFFF_FFFF; REMU x / 0 → x.
- Branch: BranchE = 1, SrcA = SrcB = 5 → PCSrcE = 1, PCTargetE = PCE + Imm. With BranchNeE = 1 → PCSrcE = 0.
- Abort: assert FlushE at cnt = 10 during a DIVU → FSM IDLE, StallE = 0, M bubble. Repeat with rst mid-op → same, plus all outputs 0. A following add completes in 1 cycle.
